// File: rtl/bus_arbiter_pkg.sv
// Shared types for the data-bus arbiter: FSM states, master ids,
// access-width encodings, address-checker verdicts and the device map.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_CHECK  = 2'd1,
        ARB_ACCESS = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_master_e;

    typedef enum logic {
        AC_VALID = 1'b0,
        AC_BAD   = 1'b1
    } ac_result_e;

    // Access widths; DM_NONE is a no-op that still runs a bus slot.
    localparam logic [2:0] DM_NONE = 3'd0;
    localparam logic [2:0] DM_B    = 3'd1;
    localparam logic [2:0] DM_H    = 3'd2;
    localparam logic [2:0] DM_W    = 3'd3;
    localparam logic [2:0] DM_BU   = 3'd4;
    localparam logic [2:0] DM_HU   = 3'd5;

    // Data memory occupies [0, DM_END); TIMER0/TIMER1 share one 32-byte
    // window at TMR_BASE (TIMER1 = TMR_BASE + 0x10).
    localparam logic [31:0] DM_END   = 32'h0000_4000;
    localparam logic [31:0] TMR_BASE = 32'h0000_7F00;

    // Natural alignment for the given width; only the low address bits matter.
    function automatic logic dm_aligned(input logic [1:0] addr_lo, input logic [2:0] mode);
        logic ok;
        case (mode)
            DM_H, DM_HU: ok = (addr_lo[0] == 1'b0);
            DM_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Encodings above DM_HU are not defined and are rejected.
    function automatic logic dm_mode_known(input logic [2:0] mode);
        return (mode <= DM_HU);
    endfunction

endpackage

// File: rtl/bus_arbiter_ac.sv
// Address checker: decides whether a latched access may reach the bus.
// Timers accept word accesses only; their upper two registers
// (offsets 0x8/0xC) are read-only.
module bus_arbiter_ac
    import bus_arbiter_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  mode,
    input  logic        we,
    output ac_result_e  result
);

    logic in_dm_s;
    logic in_tmr_s;

    // Classify the access against the device map and the register rules.
    always_comb begin
        in_dm_s  = (addr < DM_END);
        in_tmr_s = (addr[31:5] == TMR_BASE[31:5]);
        result   = AC_BAD;
        if (mode == DM_NONE) begin
            result = AC_VALID;
        end else if (!dm_mode_known(mode) || !dm_aligned(addr[1:0], mode)) begin
            result = AC_BAD;
        end else if (in_dm_s) begin
            result = AC_VALID;
        end else if (in_tmr_s) begin
            result = ((mode != DM_W) || (we && addr[3])) ? AC_BAD : AC_VALID;
        end else begin
            result = AC_BAD;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the data bus. Each granted access is
// checked, then drives the bus for ACC_LAT cycles; completion is reported
// with a one-cycle ack to the owning master only.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ACC_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [2:0]  m0_mode,
    input  logic        m0_we,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [2:0]  m1_mode,
    input  logic        m1_we,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [2:0]  bus_mode,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam logic [3:0] CNT_LAST = 4'(ACC_LAT - 32'd1);

    arb_state_e  state_q, state_d;
    arb_master_e last_q, last_d, owner_q, owner_d, grant_s;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0]  mode_q, mode_d;
    logic        we_q, we_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
    logic        m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [2:0]  bus_mode_q, bus_mode_d;
    logic        bus_we_q, bus_we_d;
    logic        fin_s, fin_err_s;
    logic [31:0] fin_rdata_s;
    ac_result_e  ac_res_s;

    bus_arbiter_ac u_ac (
        .addr   (addr_q),
        .mode   (mode_q),
        .we     (we_q),
        .result (ac_res_s)
    );

    // Next-state, latch and output-pulse computation for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        mode_d      = mode_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        bus_addr_d  = 32'h0;
        bus_mode_d  = DM_NONE;
        bus_we_d    = 1'b0;
        bus_wdata_d = 32'h0;
        fin_s       = 1'b0;
        fin_err_s   = 1'b0;
        fin_rdata_s = 32'h0;
        // On a tie the master that was not served last wins.
        grant_s = (m0_req && m1_req) ? ((last_q == ARB_M0) ? ARB_M1 : ARB_M0)
                                     : (m0_req ? ARB_M0 : ARB_M1);
        case (state_q)
            ARB_IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d = grant_s;
                    addr_d  = (grant_s == ARB_M0) ? m0_addr  : m1_addr;
                    mode_d  = (grant_s == ARB_M0) ? m0_mode  : m1_mode;
                    we_d    = (grant_s == ARB_M0) ? m0_we    : m1_we;
                    wdata_d = (grant_s == ARB_M0) ? m0_wdata : m1_wdata;
                    state_d = ARB_CHECK;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_CHECK: begin
                if (ac_res_s == AC_BAD) begin
                    fin_s     = 1'b1;
                    fin_err_s = 1'b1;
                    state_d   = ARB_DONE;
                end else begin
                    cnt_d       = 4'd0;
                    bus_addr_d  = addr_q;
                    bus_mode_d  = mode_q;
                    bus_we_d    = we_q && (mode_q != DM_NONE);
                    bus_wdata_d = wdata_q;
                    state_d     = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    fin_s       = 1'b1;
                    fin_rdata_s = (!we_q && (mode_q != DM_NONE)) ? bus_rdata : 32'h0;
                    state_d     = ARB_DONE;
                end else begin
                    bus_addr_d  = addr_q;
                    bus_mode_d  = mode_q;
                    bus_wdata_d = wdata_q;
                    state_d     = ARB_ACCESS;
                end
            end
            ARB_DONE: begin
                last_d  = owner_q;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        // Completion is steered to the owner only; the other master sees zeros.
        m0_ack_d   = fin_s && (owner_q == ARB_M0);
        m1_ack_d   = fin_s && (owner_q == ARB_M1);
        m0_err_d   = m0_ack_d && fin_err_s;
        m1_err_d   = m1_ack_d && fin_err_s;
        m0_rdata_d = m0_ack_d ? fin_rdata_s : 32'h0;
        m1_rdata_d = m1_ack_d ? fin_rdata_s : 32'h0;
    end

    // State, transaction latch and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            last_q      <= ARB_M1;
            owner_q     <= ARB_M0;
            addr_q      <= 32'h0;
            mode_q      <= DM_NONE;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            cnt_q       <= 4'd0;
            m0_ack_q    <= 1'b0;
            m0_err_q    <= 1'b0;
            m0_rdata_q  <= 32'h0;
            m1_ack_q    <= 1'b0;
            m1_err_q    <= 1'b0;
            m1_rdata_q  <= 32'h0;
            bus_addr_q  <= 32'h0;
            bus_mode_q  <= DM_NONE;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            mode_q      <= mode_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            m0_ack_q    <= m0_ack_d;
            m0_err_q    <= m0_err_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_ack_q    <= m1_ack_d;
            m1_err_q    <= m1_err_d;
            m1_rdata_q  <= m1_rdata_d;
            bus_addr_q  <= bus_addr_d;
            bus_mode_q  <= bus_mode_d;
            bus_we_q    <= bus_we_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign m0_ack    = m0_ack_q;
    assign m0_err    = m0_err_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_ack    = m1_ack_q;
    assign m1_err    = m1_err_q;
    assign m1_rdata  = m1_rdata_q;
    assign bus_addr  = bus_addr_q;
    assign bus_mode  = bus_mode_q;
    assign bus_we    = bus_we_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (ACC_LAT = 2). Inputs change on the
// falling edge; outputs are sampled on the falling edge.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int unsigned ACC_LAT = 2;

    logic        clk, reset;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [2:0]  m0_mode;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [2:0]  m1_mode;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [2:0]  bus_mode;
    logic        bus_we;

    int          n_checks, n_fail;
    int          ack0_cyc, ack1_cyc, we_cnt, acc_cnt, ovl;
    logic        err0, err1;
    logic [31:0] rd0, rd1, we_addr, we_data;

    bus_arbiter #(.ACC_LAT(ACC_LAT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_mode(m0_mode), .m0_we(m0_we),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_mode(m1_mode), .m1_we(m1_we),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_mode(bus_mode), .bus_we(bus_we),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic [31:0] a, input logic [2:0] m, input logic w, input logic [31:0] d);
        m0_addr = a; m0_mode = m; m0_we = w; m0_wdata = d; m0_req = 1'b1;
    endtask

    task automatic set_m1(input logic [31:0] a, input logic [2:0] m, input logic w, input logic [31:0] d);
        m1_addr = a; m1_mode = m; m1_we = w; m1_wdata = d; m1_req = 1'b1;
    endtask

    // Runs until every raised request is acked (or the budget expires),
    // recording ack cycle (counted from the request edge), err, rdata and bus activity.
    task automatic run_txn(input int limit);
        ack0_cyc = 0; ack1_cyc = 0; we_cnt = 0; acc_cnt = 0; ovl = 0;
        err0 = 1'b0; err1 = 1'b0; rd0 = 32'h0; rd1 = 32'h0; we_addr = 32'h0; we_data = 32'h0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (bus_we) begin we_cnt++; we_addr = bus_addr; we_data = bus_wdata; end
            if (bus_mode != DM_NONE) acc_cnt++;
            if (m0_ack && m1_ack) ovl++;
            if ((!m0_ack && (m0_err || m0_rdata != 32'h0)) || (!m1_ack && (m1_err || m1_rdata != 32'h0))) ovl++;
            if (m0_ack && ack0_cyc == 0) begin ack0_cyc = c; err0 = m0_err; rd0 = m0_rdata; m0_req = 1'b0; end
            if (m1_ack && ack1_cyc == 0) begin ack1_cyc = c; err1 = m1_err; rd1 = m1_rdata; m1_req = 1'b0; end
            if (!m0_req && !m1_req) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        m0_req = 1'b0; m0_addr = 32'h0; m0_mode = DM_NONE; m0_we = 1'b0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_addr = 32'h0; m1_mode = DM_NONE; m1_we = 1'b0; m1_wdata = 32'h0;
        bus_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        chk("rst_m0_ack",   {31'h0, m0_ack},   32'h0);
        chk("rst_m0_err",   {31'h0, m0_err},   32'h0);
        chk("rst_m0_rdata", m0_rdata,          32'h0);
        chk("rst_m1_ack",   {31'h0, m1_ack},   32'h0);
        chk("rst_m1_rdata", m1_rdata,          32'h0);
        chk("rst_bus_mode", {29'h0, bus_mode}, 32'h0);
        chk("rst_bus_we",   {31'h0, bus_we},   32'h0);
        chk("rst_bus_addr", bus_addr,          32'h0);
        reset = 1'b0;
        @(negedge clk);

        // m0 lw 0x1000
        bus_rdata = 32'hDEAD_BEEF;
        set_m0(32'h0000_1000, DM_W, 1'b0, 32'h0);
        run_txn(20);
        chk("lw_ack_cyc", 32'(ack0_cyc), 32'd4);
        chk("lw_err",     {31'h0, err0}, 32'h0);
        chk("lw_rdata",   rd0,           32'hDEAD_BEEF);
        chk("lw_we_cnt",  32'(we_cnt),   32'd0);
        chk("lw_acc_cnt", 32'(acc_cnt),  32'd2);
        chk("lw_m1_ack",  32'(ack1_cyc), 32'd0);
        chk("lw_ovl",     32'(ovl),      32'd0);

        // Tie straight after reset: m0 first, m1 in the IDLE after m0's DONE
        do_reset();
        bus_rdata = 32'h1234_5678;
        set_m0(32'h0000_1004, DM_W, 1'b0, 32'h0);
        set_m1(32'h0000_2000, DM_W, 1'b0, 32'h0);
        run_txn(30);
        chk("tie_m0_cyc", 32'(ack0_cyc), 32'd4);
        chk("tie_m1_cyc", 32'(ack1_cyc), 32'd9);
        chk("tie_m1_rd",  rd1,           32'h1234_5678);
        chk("tie_ovl",    32'(ovl),      32'd0);

        // m1 sw TIMER0 base
        set_m1(32'h0000_7F00, DM_W, 1'b1, 32'h0000_0009);
        run_txn(20);
        chk("sw_ack_cyc", 32'(ack1_cyc), 32'd4);
        chk("sw_err",     {31'h0, err1}, 32'h0);
        chk("sw_rdata",   rd1,           32'h0);
        chk("sw_we_cnt",  32'(we_cnt),   32'd1);
        chk("sw_we_addr", we_addr,       32'h0000_7F00);
        chk("sw_we_data", we_data,       32'h0000_0009);

        // m0 sw to read-only timer register with same-cycle m1 load (last = m1)
        bus_rdata = 32'h0BAD_F00D;
        set_m0(32'h0000_7F08, DM_W, 1'b1, 32'h0000_0001);
        set_m1(32'h0000_0100, DM_W, 1'b0, 32'h0);
        run_txn(30);
        chk("ro_m0_cyc", 32'(ack0_cyc), 32'd2);
        chk("ro_m0_err", {31'h0, err0}, 32'h1);
        chk("ro_m1_cyc", 32'(ack1_cyc), 32'd7);
        chk("ro_m1_err", {31'h0, err1}, 32'h0);
        chk("ro_m1_rd",  rd1,           32'h0BAD_F00D);
        chk("ro_we_cnt", 32'(we_cnt),   32'd0);

        // m0 sh to TIMER0 (bad mode)
        set_m0(32'h0000_7F00, DM_H, 1'b1, 32'h0000_00FF);
        run_txn(20);
        chk("sh_ack_cyc", 32'(ack0_cyc), 32'd2);
        chk("sh_err",     {31'h0, err0}, 32'h1);
        chk("sh_we_cnt",  32'(we_cnt),   32'd0);
        chk("sh_acc_cnt", 32'(acc_cnt),  32'd0);

        // m0 lw misaligned
        set_m0(32'h0000_1002, DM_W, 1'b0, 32'h0);
        run_txn(20);
        chk("mis_ack_cyc", 32'(ack0_cyc), 32'd2);
        chk("mis_err",     {31'h0, err0}, 32'h1);
        chk("mis_rdata",   rd0,           32'h0);

        // m0 lb odd address in DM is legal
        bus_rdata = 32'h0000_00A5;
        set_m0(32'h0000_1003, DM_B, 1'b0, 32'h0);
        run_txn(20);
        chk("lb_ack_cyc", 32'(ack0_cyc), 32'd4);
        chk("lb_err",     {31'h0, err0}, 32'h0);
        chk("lb_rdata",   rd0,           32'h0000_00A5);

        // m1 load outside every device
        set_m1(32'h0001_0000, DM_W, 1'b0, 32'h0);
        run_txn(20);
        chk("oom_ack_cyc", 32'(ack1_cyc), 32'd2);
        chk("oom_err",     {31'h0, err1}, 32'h1);

        // DM_NONE request: full slot, no strobe, no data
        set_m1(32'h0000_0123, DM_NONE, 1'b1, 32'h0000_0077);
        run_txn(20);
        chk("none_ack_cyc", 32'(ack1_cyc), 32'd4);
        chk("none_err",     {31'h0, err1}, 32'h0);
        chk("none_rdata",   rd1,           32'h0);
        chk("none_we_cnt",  32'(we_cnt),   32'd0);
        chk("none_acc_cnt", 32'(acc_cnt),  32'd0);

        // Reset pulsed in the first ACCESS cycle of a store
        set_m0(32'h0000_0200, DM_W, 1'b1, 32'h0000_0055);
        @(negedge clk);
        @(negedge clk);
        chk("mid_we_pre",  {31'h0, bus_we}, 32'h1);
        reset = 1'b1;
        m0_req = 1'b0;
        #1;
        chk("mid_we",   {31'h0, bus_we},   32'h0);
        chk("mid_mode", {29'h0, bus_mode}, 32'h0);
        chk("mid_addr", bus_addr,          32'h0);
        chk("mid_ack",  {31'h0, m0_ack},   32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_rdata = 32'hCAFE_0001;
        set_m1(32'h0000_3000, DM_W, 1'b0, 32'h0);
        run_txn(20);
        chk("post_ack_cyc", 32'(ack1_cyc), 32'd4);
        chk("post_err",     {31'h0, err1}, 32'h0);
        chk("post_rdata",   rd1,           32'hCAFE_0001);
        chk("post_m0_ack",  32'(ack0_cyc), 32'd0);
        chk("post_we_cnt",  32'(we_cnt),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
